// File: rtl/bp_dma_mem_responder_pkg.sv
// ============================================================================
// bp_dma_mem_responder_pkg : shared types for the DMA memory responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package bp_dma_mem_responder_pkg;

   typedef enum logic [1:0] {
      e_idle    = 2'd0,
      e_rd_wait = 2'd1,
      e_rd_data = 2'd2,
      e_wr_data = 2'd3
   } bp_dma_resp_state_e;

   localparam int unsigned c_count_width = 32;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bp_dma_mem_responder_mem.sv
// ============================================================================
// bp_dma_mem_responder_mem : 1R1W backing store, synchronous write, async read
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_dma_mem_responder_mem #(
   parameter int width_p      = 64,
   parameter int els_p        = 4096,
   parameter int addr_width_p = 12
) (
   input  logic                    clk_i,
   input  logic                    w_v_i,
   input  logic [addr_width_p-1:0] w_addr_i,
   input  logic [width_p-1:0]      w_data_i,
   input  logic [addr_width_p-1:0] r_addr_i,
   output logic [width_p-1:0]      r_data_o
);

   logic [width_p-1:0] mem_q [els_p];

   always_ff @(posedge clk_i) begin
      if (w_v_i) begin
         mem_q[w_addr_i] <= w_data_i;
      end
   end

   assign r_data_o = mem_q[r_addr_i];

endmodule

`default_nettype wire

// File: rtl/bp_dma_mem_responder.sv
// ============================================================================
// bp_dma_mem_responder : serves bsg_cache DMA read/write bursts from a store
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_dma_mem_responder
   import bp_dma_mem_responder_pkg::*;
#(
   parameter int daddr_width_p  = 28,
   parameter int fill_width_p   = 64,
   parameter int burst_len_p    = 8,
   parameter int mem_els_p      = 4096,
   parameter int read_latency_p = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [daddr_width_p:0]   dma_pkt_i,
   input  logic                     dma_pkt_v_i,
   output logic                     dma_pkt_ready_and_o,
   input  logic [fill_width_p-1:0]  dma_data_i,
   input  logic                     dma_data_v_i,
   output logic                     dma_data_ready_and_o,
   output logic [fill_width_p-1:0]  dma_data_o,
   output logic                     dma_data_v_o,
   input  logic                     dma_data_ready_and_i,
   output logic [c_count_width-1:0] rd_count_o,
   output logic [c_count_width-1:0] wr_count_o
);

   localparam int c_idx_w    = clog2_min1(mem_els_p);
   localparam int c_beat_w   = clog2_min1(burst_len_p);
   localparam int c_lat_w    = clog2_min1(read_latency_p);
   localparam int c_offs     = $clog2(fill_width_p / 8);
   localparam int c_blk      = $clog2(burst_len_p);
   localparam int c_lat_last = (read_latency_p > 0) ? read_latency_p - 1 : 0;
   localparam logic [daddr_width_p-1:0] c_blk_mask = ~(daddr_width_p'((2 ** c_blk) - 1));

   bp_dma_resp_state_e state_q, state_d;

   logic [c_idx_w-1:0]       idx_q, idx_d;
   logic [c_beat_w-1:0]      beat_cnt_q, beat_cnt_d;
   logic [c_lat_w-1:0]       lat_cnt_q, lat_cnt_d;
   logic [c_count_width-1:0] rd_count_q, rd_count_d;
   logic [c_count_width-1:0] wr_count_q, wr_count_d;

   logic                     w_write_not_read;
   logic [daddr_width_p-1:0] w_addr;
   logic [daddr_width_p-1:0] w_aligned;
   logic [c_idx_w-1:0]       w_start_idx;
   logic [c_idx_w-1:0]       w_idx_inc;
   logic                     w_pkt_hs;
   logic                     w_rd_hs;
   logic                     w_wr_hs;
   logic                     w_last;
   logic                     w_lat_done;

   assign w_write_not_read = dma_pkt_i[daddr_width_p];
   assign w_addr           = dma_pkt_i[daddr_width_p-1:0];

   // Byte address -> beat index, rounded down to the block, then folded into the store.
   assign w_aligned   = (w_addr >> c_offs) & c_blk_mask;
   assign w_start_idx = c_idx_w'(w_aligned % daddr_width_p'(mem_els_p));
   assign w_idx_inc   = (idx_q == c_idx_w'(mem_els_p - 1)) ? '0 : idx_q + c_idx_w'(1);

   assign w_pkt_hs   = (state_q == e_idle) && dma_pkt_v_i;
   assign w_rd_hs    = (state_q == e_rd_data) && dma_data_ready_and_i;
   assign w_wr_hs    = (state_q == e_wr_data) && dma_data_v_i;
   assign w_last     = (beat_cnt_q == c_beat_w'(burst_len_p - 1));
   assign w_lat_done = (lat_cnt_q == c_lat_w'(c_lat_last));

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= e_idle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         e_idle: begin
            if (dma_pkt_v_i) begin
               if (w_write_not_read)         state_d = e_wr_data;
               else if (read_latency_p == 0) state_d = e_rd_data;
               else                          state_d = e_rd_wait;
            end
         end
         e_rd_wait: if (w_lat_done)                          state_d = e_rd_data;
         e_rd_data: if (dma_data_ready_and_i && w_last)      state_d = e_idle;
         e_wr_data: if (dma_data_v_i && w_last)              state_d = e_idle;
         default:                                            state_d = e_idle;
      endcase
   end

   always_comb begin
      dma_pkt_ready_and_o  = (state_q == e_idle);
      dma_data_v_o         = (state_q == e_rd_data);
      dma_data_ready_and_o = (state_q == e_wr_data);
   end

   always_comb begin
      idx_d      = idx_q;
      beat_cnt_d = beat_cnt_q;
      lat_cnt_d  = lat_cnt_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (w_pkt_hs) begin
         idx_d      = w_start_idx;
         beat_cnt_d = '0;
         lat_cnt_d  = '0;
      end
      if (state_q == e_rd_wait) begin
         lat_cnt_d = lat_cnt_q + c_lat_w'(1);
      end
      if (w_rd_hs || w_wr_hs) begin
         idx_d      = w_idx_inc;
         beat_cnt_d = beat_cnt_q + c_beat_w'(1);
      end
      if (w_rd_hs && w_last && (rd_count_q != '1)) begin
         rd_count_d = rd_count_q + c_count_width'(1);
      end
      if (w_wr_hs && w_last && (wr_count_q != '1)) begin
         wr_count_d = wr_count_q + c_count_width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         idx_q      <= '0;
         beat_cnt_q <= '0;
         lat_cnt_q  <= '0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         idx_q      <= idx_d;
         beat_cnt_q <= beat_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign rd_count_o = rd_count_q;
   assign wr_count_o = wr_count_q;

   bp_dma_mem_responder_mem #(
      .width_p      (fill_width_p),
      .els_p        (mem_els_p),
      .addr_width_p (c_idx_w)
   ) u_mem (
      .clk_i    (clk_i),
      .w_v_i    (w_wr_hs),
      .w_addr_i (idx_q),
      .w_data_i (dma_data_i),
      .r_addr_i (idx_q),
      .r_data_o (dma_data_o)
   );

endmodule

`default_nettype wire

// File: tb/tb_bp_dma_mem_responder.sv
// ============================================================================
// tb_bp_dma_mem_responder : scoreboard bench, one 4-cycle-latency instance and
// one zero-latency instance with a non-power-of-2 store. Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bp_dma_mem_responder;

   localparam int AW = 28;
   localparam int DW = 64;
   localparam int BL = 8;

   typedef logic [DW-1:0] blk_t [BL];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n;
   logic [AW:0]   pkt     [2];
   logic          pkt_v   [2];
   logic          pkt_rdy [2];
   logic [DW-1:0] wdata   [2];
   logic          wv      [2];
   logic          wrdy    [2];
   logic [DW-1:0] rdata   [2];
   logic          rv      [2];
   logic          rrdy    [2];
   logic [31:0]   rd_cnt  [2];
   logic [31:0]   wr_cnt  [2];

   int checks;
   int errors;
   logic [DW-1:0] exp_q0[$];
   logic [DW-1:0] exp_q1[$];
   int            hs_cnt     [2];
   time           last_hs_t  [2];
   bit            stall_prev [2];
   logic [DW-1:0] prev_data  [2];

   bp_dma_mem_responder #(
      .daddr_width_p(AW), .fill_width_p(DW), .burst_len_p(BL),
      .mem_els_p(4096), .read_latency_p(4)
   ) u_dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .dma_pkt_i(pkt[0]), .dma_pkt_v_i(pkt_v[0]), .dma_pkt_ready_and_o(pkt_rdy[0]),
      .dma_data_i(wdata[0]), .dma_data_v_i(wv[0]), .dma_data_ready_and_o(wrdy[0]),
      .dma_data_o(rdata[0]), .dma_data_v_o(rv[0]), .dma_data_ready_and_i(rrdy[0]),
      .rd_count_o(rd_cnt[0]), .wr_count_o(wr_cnt[0])
   );

   bp_dma_mem_responder #(
      .daddr_width_p(AW), .fill_width_p(DW), .burst_len_p(BL),
      .mem_els_p(4092), .read_latency_p(0)
   ) u_dut_lat0 (
      .clk_i(clk), .reset_n_i(reset_n),
      .dma_pkt_i(pkt[1]), .dma_pkt_v_i(pkt_v[1]), .dma_pkt_ready_and_o(pkt_rdy[1]),
      .dma_data_i(wdata[1]), .dma_data_v_i(wv[1]), .dma_data_ready_and_o(wrdy[1]),
      .dma_data_o(rdata[1]), .dma_data_v_o(rv[1]), .dma_data_ready_and_i(rrdy[1]),
      .rd_count_o(rd_cnt[1]), .wr_count_o(wr_cnt[1])
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic blk_t seq(input logic [DW-1:0] v0);
      blk_t b;
      for (int i = 0; i < BL; i++) b[i] = v0 + DW'(i);
      return b;
   endfunction

   // Monitor: pops the scoreboard on every read handshake and checks stall stability.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      for (int d = 0; d < 2; d++) begin
         if (!reset_n) begin
            stall_prev[d] = 1'b0;
         end else begin
            if (stall_prev[d]) begin
               chk($sformatf("stall_hold_valid[%0d]", d), 64'(rv[d]), 64'd1);
               chk($sformatf("stall_hold_data[%0d]", d), rdata[d], prev_data[d]);
            end
            if (rv[d] && rrdy[d]) begin
               if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_beat[%0d]: got 0x%0h expected no beat", d, rdata[d]);
               end else begin
                  e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                  chk($sformatf("rd_beat[%0d]", d), rdata[d], e);
               end
               hs_cnt[d]++;
               last_hs_t[d] = $time;
            end
            stall_prev[d] = rv[d] && !rrdy[d];
            prev_data[d]  = rdata[d];
         end
      end
   end

   task automatic send_pkt(input int d, input bit wnr, input logic [AW-1:0] addr);
      int n;
      pkt[d]   = {wnr, addr};
      pkt_v[d] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!pkt_rdy[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!pkt_rdy[d]) chk("pkt_ready_timeout", 64'(pkt_rdy[d]), 64'd1);
      @(posedge clk);
      #1;
      pkt_v[d] = 1'b0;
   endtask

   task automatic write_block(input int d, input logic [AW-1:0] addr, input logic [DW-1:0] v0,
                              input bit hold);
      int n;
      send_pkt(d, 1'b1, addr);
      wv[d] = 1'b1;
      for (int i = 0; i < BL; i++) begin
         wdata[d] = v0 + DW'(i);
         n = 0;
         @(negedge clk);
         if (i == 0) chk("wr_ready_at_T+1", 64'(wrdy[d]), 64'd1);
         while (!wrdy[d] && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!wrdy[d]) chk("wr_beat_timeout", 64'(wrdy[d]), 64'd1);
         @(posedge clk);
         #1;
      end
      chk("pkt_ready_after_wr", 64'(pkt_rdy[d]), 64'd1);
      if (hold) begin
         wdata[d] = '1;
         repeat (3) begin
            @(negedge clk);
            chk("wr_ready_after_last", 64'(wrdy[d]), 64'd0);
         end
         @(posedge clk);
         #1;
      end
      wv[d] = 1'b0;
   endtask

   task automatic read_block(input int d, input logic [AW-1:0] addr, input blk_t ev,
                             input bit bp, input int exp_lat);
      int lat, target, start, n, k;
      time t0;
      for (int i = 0; i < BL; i++) begin
         if (d == 0) exp_q0.push_back(ev[i]);
         else        exp_q1.push_back(ev[i]);
      end
      start  = hs_cnt[d];
      target = start + BL;
      rrdy[d] = !bp;
      send_pkt(d, 1'b0, addr);
      lat = 0;
      @(negedge clk);
      while (!rv[d] && lat < 50) begin
         lat++;
         @(negedge clk);
      end
      t0 = $time;
      chk("rd_first_beat_latency", 64'(lat), 64'(exp_lat));
      k = 0;
      n = 0;
      while (hs_cnt[d] < target && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (bp && hs_cnt[d] < target) begin
            rrdy[d] = (k % 3 == 0);
            k++;
         end
      end
      chk("rd_handshakes", 64'(hs_cnt[d] - start), 64'(BL));
      chk("pkt_ready_after_rd", 64'(pkt_rdy[d]), 64'd1);
      chk("rd_valid_after_last", 64'(rv[d]), 64'd0);
      if (!bp) chk("rd_one_beat_per_cycle", 64'(last_hs_t[d] - t0), 64'd70);
      chk("rd_scoreboard_drained", 64'((d == 0) ? exp_q0.size() : exp_q1.size()), 64'd0);
      rrdy[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      blk_t b;
      int n, start;
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         pkt[d] = '0; pkt_v[d] = 1'b0; wdata[d] = '0; wv[d] = 1'b0; rrdy[d] = 1'b0;
         hs_cnt[d] = 0; last_hs_t[d] = 0; stall_prev[d] = 1'b0; prev_data[d] = '0;
      end
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_pkt_ready", 64'(pkt_rdy[d]), 64'd1);
         chk("reset_rd_valid", 64'(rv[d]), 64'd0);
         chk("reset_wr_ready", 64'(wrdy[d]), 64'd0);
         chk("reset_rd_count", 64'(rd_cnt[d]), 64'd0);
         chk("reset_wr_count", 64'(wr_cnt[d]), 64'd0);
      end
      @(posedge clk);
      #1;

      // Write then read back with the consumer always ready.
      write_block(0, 28'h100, 64'h11, 1'b0);
      read_block(0, 28'h100, seq(64'h11), 1'b0, 4);
      chk("wr_count_after_t1", 64'(wr_cnt[0]), 64'd1);
      chk("rd_count_after_t1", 64'(rd_cnt[0]), 64'd1);

      // Backpressure.
      write_block(0, 28'h400, 64'hA0, 1'b0);
      read_block(0, 28'h400, seq(64'hA0), 1'b1, 4);
      chk("rd_count_after_bp", 64'(rd_cnt[0]), 64'd2);

      // Last block, unaligned read, and an address beyond the store folding back.
      write_block(0, 28'h7FC0, 64'hC0, 1'b0);
      read_block(0, 28'h7FD8, seq(64'hC0), 1'b0, 4);
      read_block(0, 28'h8100, seq(64'h11), 1'b0, 4);

      // Write beats offered before the packet are held off; nothing spills past the block.
      write_block(0, 28'h240, 64'hE0, 1'b0);
      wv[0]    = 1'b1;
      wdata[0] = 64'h5A;
      repeat (3) begin
         @(negedge clk);
         chk("wr_holdoff_idle", 64'(wrdy[0]), 64'd0);
      end
      @(posedge clk);
      #1;
      write_block(0, 28'h200, 64'h31, 1'b1);
      read_block(0, 28'h240, seq(64'hE0), 1'b0, 4);
      read_block(0, 28'h200, seq(64'h31), 1'b0, 4);
      chk("wr_count_after_holdoff", 64'(wr_cnt[0]), 64'd5);
      chk("rd_count_after_holdoff", 64'(rd_cnt[0]), 64'd6);

      // Asynchronous reset after read beat 3.
      b = seq(64'h11);
      for (int i = 0; i < BL; i++) exp_q0.push_back(b[i]);
      start   = hs_cnt[0];
      rrdy[0] = 1'b1;
      send_pkt(0, 1'b0, 28'h100);
      n = 0;
      while (hs_cnt[0] < start + 4 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("reset_test_beats_before", 64'(hs_cnt[0] - start), 64'd4);
      #3 reset_n = 1'b0;
      #1;
      chk("midreset_rd_valid", 64'(rv[0]), 64'd0);
      chk("midreset_rd_count", 64'(rd_cnt[0]), 64'd0);
      chk("midreset_wr_count", 64'(wr_cnt[0]), 64'd0);
      chk("midreset_wr_count_lat0", 64'(wr_cnt[1]), 64'd0);
      exp_q0.delete();
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(negedge clk);
      chk("postreset_pkt_ready", 64'(pkt_rdy[0]), 64'd1);
      chk("postreset_wr_ready", 64'(wrdy[0]), 64'd0);
      rrdy[0] = 1'b0;
      @(posedge clk);
      #1;
      read_block(0, 28'h100, seq(64'h11), 1'b0, 4);
      chk("rd_count_after_reset_read", 64'(rd_cnt[0]), 64'd1);

      // Zero-latency instance: burst at index 4088 of a 4092-entry store wraps to index 0.
      write_block(1, 28'h0, 64'h61, 1'b0);
      write_block(1, 28'h7FC0, 64'h71, 1'b0);
      read_block(1, 28'h7FC0, seq(64'h71), 1'b0, 0);
      b[0] = 64'h75; b[1] = 64'h76; b[2] = 64'h77; b[3] = 64'h78;
      b[4] = 64'h65; b[5] = 64'h66; b[6] = 64'h67; b[7] = 64'h68;
      read_block(1, 28'h0, b, 1'b0, 0);
      chk("lat0_wr_count", 64'(wr_cnt[1]), 64'd2);
      chk("lat0_rd_count", 64'(rd_cnt[1]), 64'd2);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
